// File: rtl/bus_fabric.sv
// Single-master, N-slave interconnect: region decode into one-hot strobes,
// rvalid/wready handshakes, per-access timeout and sticky error reporting.
module bus_fabric #(
  parameter int unsigned N_SLAVES = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SEL_MSB  = 31,
  parameter int unsigned SEL_LSB  = 28,
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                m_addr,
  input  logic [DATA_W-1:0]          m_wdata,
  input  logic [DATA_W/8-1:0]        m_wmask,
  input  logic                       m_rstrb,
  output logic [DATA_W-1:0]          m_rdata,
  output logic                       m_rbusy,
  output logic                       m_wbusy,
  output logic [31:0]                s_addr,
  output logic [DATA_W-1:0]          s_wdata,
  output logic [DATA_W/8-1:0]        s_wstrb,
  output logic [N_SLAVES-1:0]        s_ren,
  output logic [N_SLAVES-1:0]        s_wen,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [N_SLAVES-1:0]        s_rvalid,
  input  logic [N_SLAVES-1:0]        s_wready,
  output logic                       err,
  output logic [31:0]                err_addr,
  input  logic                       err_clr
);
  localparam int unsigned SEL_W = SEL_MSB - SEL_LSB + 1;
  localparam int unsigned TGT_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, ERR} state_e;

  state_e            state_q, state_d;
  logic [TGT_W-1:0]  tgt_q, tgt_d;
  logic              is_rd_q, is_rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] m_rdata_q, m_rdata_d;
  logic              m_rbusy_q, m_rbusy_d;
  logic              m_wbusy_q, m_wbusy_d;
  logic              err_q, err_d;
  logic [31:0]       err_addr_q, err_addr_d;

  logic [SEL_W-1:0]  idx;
  logic              mapped, rd_req, wr_req, timeout_hit;
  logic              wready_idx, rvalid_tgt, wready_tgt;
  logic [DATA_W-1:0] rdata_tgt;

  assign idx         = m_addr[SEL_MSB:SEL_LSB];
  assign mapped      = 32'(idx) < N_SLAVES;
  assign wr_req      = |m_wmask;
  assign rd_req      = m_rstrb & ~wr_req;
  assign timeout_hit = (9'(cnt_q) + 9'd1) >= 9'(TIMEOUT);

  assign s_addr   = 32'(m_addr[SEL_LSB-1:0]);
  assign s_wdata  = m_wdata;
  assign s_wstrb  = m_wmask;
  assign m_rdata  = m_rdata_q;
  assign m_rbusy  = m_rbusy_q;
  assign m_wbusy  = m_wbusy_q;
  assign err      = err_q;
  assign err_addr = err_addr_q;

  // Slave-side muxing: strobes and same-cycle wready follow the live decode,
  // wait-state handshakes follow the registered target.
  always_comb begin
    s_ren      = '0;
    s_wen      = '0;
    wready_idx = 1'b0;
    rvalid_tgt = 1'b0;
    wready_tgt = 1'b0;
    rdata_tgt  = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (idx == SEL_W'(i)) begin
        wready_idx = s_wready[i];
        if (state_q == IDLE) begin
          s_ren[i] = rd_req;
          s_wen[i] = wr_req;
        end
      end
      if (tgt_q == TGT_W'(i)) begin
        rvalid_tgt = s_rvalid[i];
        wready_tgt = s_wready[i];
        rdata_tgt  = s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    is_rd_d    = is_rd_q;
    cnt_d      = '0;
    m_rdata_d  = m_rdata_q;
    err_d      = err_q & ~err_clr;
    err_addr_d = err_addr_q;
    case (state_q)
      IDLE: begin
        if (rd_req || wr_req) begin
          is_rd_d = rd_req;
          tgt_d   = TGT_W'(idx);
          if (!mapped)         state_d = ERR;
          else if (rd_req)     state_d = RD_WAIT;
          else if (!wready_idx) state_d = WR_WAIT;
        end
      end
      RD_WAIT: begin
        if (rvalid_tgt) begin
          m_rdata_d = rdata_tgt;
          state_d   = IDLE;
        end else if (timeout_hit) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WR_WAIT: begin
        if (wready_tgt)       state_d = IDLE;
        else if (timeout_hit) state_d = ERR;
        else                  cnt_d = cnt_q + CNT_W'(1);
      end
      ERR: begin
        // Set beats a simultaneous clear; address kept from the first error.
        if (is_rd_q) m_rdata_d = DATA_W'(ERR_DATA);
        if (!err_q)  err_addr_d = m_addr;
        err_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    m_rbusy_d = (state_d == RD_WAIT) || ((state_d == ERR) && is_rd_d);
    m_wbusy_d = (state_d == WR_WAIT) || ((state_d == ERR) && !is_rd_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tgt_q      <= '0;
      is_rd_q    <= 1'b0;
      cnt_q      <= '0;
      m_rdata_q  <= '0;
      m_rbusy_q  <= 1'b0;
      m_wbusy_q  <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      is_rd_q    <= is_rd_d;
      cnt_q      <= cnt_d;
      m_rdata_q  <= m_rdata_d;
      m_rbusy_q  <= m_rbusy_d;
      m_wbusy_q  <= m_wbusy_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end
endmodule

// File: tb/tb_bus_fabric.sv
// Self-checking bench for bus_fabric: directed scenarios plus randomized
// accesses checked against a transaction-level reference model.
module tb_bus_fabric;
  localparam int          NS   = 4;
  localparam int          TO   = 15;
  localparam int          NEVER = 1000;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  m_addr, m_wdata, m_rdata, s_addr, s_wdata, err_addr;
  logic [3:0]   m_wmask, s_wstrb, s_ren, s_wen, s_rvalid, s_wready;
  logic         m_rstrb, m_rbusy, m_wbusy, err, err_clr;
  logic [127:0] s_rdata;

  bus_fabric #(.N_SLAVES(NS), .DATA_W(32), .SEL_MSB(31), .SEL_LSB(28),
               .TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .clk(clk), .rst(rst), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_rstrb(m_rstrb), .m_rdata(m_rdata), .m_rbusy(m_rbusy), .m_wbusy(m_wbusy),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_ren(s_ren),
    .s_wen(s_wen), .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_wready(s_wready),
    .err(err), .err_addr(err_addr), .err_clr(err_clr));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] exp_rdata, exp_err_addr;
  logic        exp_err;

  // Observations of the most recent access
  logic [3:0]  ob_ren, ob_wen, ob_wstrb;
  logic [31:0] ob_saddr, ob_swdata, ob_mwdata, ob_rdata;
  int          ob_rb, ob_wb, ob_strobes;
  bit          ob_hang;

  // Drives one core request (1-cycle pulse) with the target slave answering
  // in cycle 'lat' after the strobe; other slaves toggle their handshakes.
  task automatic run_access(input bit rd, input logic [3:0] wm, input logic [31:0] addr,
                            input int lat, input logic [31:0] sdata, input int clr_cyc);
    int idx;
    idx = int'(addr[31:28]);
    ob_rb = 0; ob_wb = 0; ob_strobes = 0; ob_hang = 1'b1;
    for (int c = 0; c <= 60; c++) begin
      @(negedge clk);
      m_rstrb  = (c == 0) ? rd : 1'b0;
      m_wmask  = (c == 0) ? wm : 4'h0;
      m_addr   = addr;
      m_wdata  = $urandom;
      err_clr  = (c == clr_cyc);
      s_rvalid = 4'($urandom);
      s_wready = 4'($urandom);
      for (int i = 0; i < NS; i++) s_rdata[i*32 +: 32] = $urandom;
      if (idx < NS) begin
        if (c > 0) s_rvalid[idx] = (c == lat);
        s_wready[idx] = (c == lat);
        s_rdata[idx*32 +: 32] = sdata;
      end
      #1;
      ob_strobes += $countones(s_ren) + $countones(s_wen);
      if (c == 0) begin
        ob_ren = s_ren; ob_wen = s_wen; ob_wstrb = s_wstrb;
        ob_saddr = s_addr; ob_swdata = s_wdata; ob_mwdata = m_wdata;
      end else begin
        if (m_rbusy) ob_rb++;
        if (m_wbusy) ob_wb++;
        if (!m_rbusy && !m_wbusy) begin
          ob_rdata = m_rdata;
          ob_hang  = 1'b0;
          break;
        end
      end
    end
    err_clr = 1'b0;
  endtask

  // Transaction-level model: a slave answering L cycles after the strobe keeps
  // the core busy L cycles; silence past TIMEOUT costs TIMEOUT+1 busy cycles.
  task automatic model_access(input bit wr, input logic [31:0] addr, input int lat,
                              input logic [31:0] sdata, input bit clr0,
                              output int busy_e, output bit err_e);
    bit mapped;
    mapped = int'(addr[31:28]) < NS;
    if (!mapped)                   busy_e = 1;
    else if (wr && lat == 0)       busy_e = 0;
    else if (lat >= 1 && lat <= TO) busy_e = lat;
    else                           busy_e = TO + 1;
    err_e = !mapped || (lat > TO);
    if (clr0) exp_err = 1'b0;
    if (err_e) begin
      if (!exp_err) exp_err_addr = addr;
      exp_err = 1'b1;
    end
    if (!wr) exp_rdata = err_e ? ERRD : sdata;
  endtask

  task automatic clear_err();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    exp_err = 1'b0;
    #1;
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL err_clr: got %b want 0", err); end
  endtask

  task automatic test_reset();
    rst = 1'b1; m_addr = '0; m_wdata = '0; m_wmask = '0; m_rstrb = 1'b0;
    s_rdata = '0; s_rvalid = '0; s_wready = '0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (m_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", m_rdata); end
    n_vec++; if (m_rbusy !== 1'b0) begin n_err++; $display("FAIL rst_rbusy: got %b want 0", m_rbusy); end
    n_vec++; if (m_wbusy !== 1'b0) begin n_err++; $display("FAIL rst_wbusy: got %b want 0", m_wbusy); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", err); end
    n_vec++; if (err_addr !== 32'h0) begin n_err++; $display("FAIL rst_err_addr: got %h want 0", err_addr); end
    @(negedge clk); rst = 1'b0;
    exp_rdata = '0; exp_err = 1'b0; exp_err_addr = '0;
  endtask

  task automatic test_read_basic();
    int be; bit ee;
    run_access(1'b1, 4'h0, 32'h0000_0100, 1, 32'h1234_5678, -1);
    model_access(1'b0, 32'h0000_0100, 1, 32'h1234_5678, 1'b0, be, ee);
    n_vec++; if (ob_hang) begin n_err++; $display("FAIL rd_hang: access never completed"); end
    n_vec++; if (ob_ren !== 4'b0001) begin n_err++; $display("FAIL rd_ren: got %b want 0001", ob_ren); end
    n_vec++; if (ob_strobes !== 1) begin n_err++; $display("FAIL rd_pulses: got %0d want 1", ob_strobes); end
    n_vec++; if (ob_rb !== be) begin n_err++; $display("FAIL rd_busy: got %0d want %0d", ob_rb, be); end
    n_vec++; if (ob_wb !== 0) begin n_err++; $display("FAIL rd_wbusy: got %0d want 0", ob_wb); end
    n_vec++; if (ob_rdata !== 32'h1234_5678) begin n_err++; $display("FAIL rd_data: got %h want 12345678", ob_rdata); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rd_err: got %b want 0", err); end
  endtask

  task automatic test_write();
    int be; bit ee;
    run_access(1'b0, 4'b0011, 32'h2000_0ABC, 3, 32'h0, -1);
    model_access(1'b1, 32'h2000_0ABC, 3, 32'h0, 1'b0, be, ee);
    n_vec++; if (ob_wen !== 4'b0100 || ob_ren !== 4'b0000) begin n_err++; $display("FAIL wr_strobe: got wen %b ren %b want 0100/0000", ob_wen, ob_ren); end
    n_vec++; if (ob_strobes !== 1) begin n_err++; $display("FAIL wr_pulses: got %0d want 1", ob_strobes); end
    n_vec++; if (ob_wstrb !== 4'b0011) begin n_err++; $display("FAIL wr_wstrb: got %b want 0011", ob_wstrb); end
    n_vec++; if (ob_saddr !== 32'h0000_0ABC) begin n_err++; $display("FAIL wr_saddr: got %h want 00000abc", ob_saddr); end
    n_vec++; if (ob_swdata !== ob_mwdata) begin n_err++; $display("FAIL wr_wdata: got %h want %h", ob_swdata, ob_mwdata); end
    n_vec++; if (ob_wb !== 3 || ob_wb !== be) begin n_err++; $display("FAIL wr_busy: got %0d want 3", ob_wb); end
    n_vec++; if (ob_rdata !== exp_rdata) begin n_err++; $display("FAIL wr_rdata_kept: got %h want %h", ob_rdata, exp_rdata); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL wr_err: got %b want 0", err); end
  endtask

  task automatic test_unmapped();
    int be; bit ee;
    run_access(1'b1, 4'h0, 32'h5000_0010, 1, 32'h0, -1);
    model_access(1'b0, 32'h5000_0010, 1, 32'h0, 1'b0, be, ee);
    n_vec++; if (ob_strobes !== 0) begin n_err++; $display("FAIL um_strobe: got %0d pulses want 0", ob_strobes); end
    n_vec++; if (ob_rb !== be) begin n_err++; $display("FAIL um_busy: got %0d want %0d", ob_rb, be); end
    n_vec++; if (ob_rdata !== ERRD) begin n_err++; $display("FAIL um_data: got %h want deadbeef", ob_rdata); end
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL um_err: got %b want 1", err); end
    n_vec++; if (err_addr !== 32'h5000_0010) begin n_err++; $display("FAIL um_err_addr: got %h want 50000010", err_addr); end
  endtask

  task automatic test_timeout();
    int be; bit ee;
    clear_err();
    run_access(1'b1, 4'h0, 32'h1000_0020, NEVER, 32'h0, -1);
    model_access(1'b0, 32'h1000_0020, NEVER, 32'h0, 1'b0, be, ee);
    n_vec++; if (ob_rb !== TO + 1) begin n_err++; $display("FAIL to_busy: got %0d want %0d", ob_rb, TO + 1); end
    n_vec++; if (ob_rdata !== ERRD) begin n_err++; $display("FAIL to_data: got %h want deadbeef", ob_rdata); end
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL to_err: got %b want 1", err); end
    n_vec++; if (err_addr !== 32'h1000_0020) begin n_err++; $display("FAIL to_err_addr: got %h want 10000020", err_addr); end
    // Second error with err_clr in its ERR cycle: set wins, address kept
    run_access(1'b0, 4'hF, 32'hF000_0004, 1, 32'h0, 1);
    model_access(1'b1, 32'hF000_0004, 1, 32'h0, 1'b0, be, ee);
    n_vec++; if (ob_wb !== 1) begin n_err++; $display("FAIL to2_busy: got %0d want 1", ob_wb); end
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL to2_set_wins: got %b want 1", err); end
    n_vec++; if (err_addr !== 32'h1000_0020) begin n_err++; $display("FAIL to2_err_addr: got %h want 10000020", err_addr); end
    n_vec++; if (ob_rdata !== ERRD) begin n_err++; $display("FAIL to2_rdata_kept: got %h want deadbeef", ob_rdata); end
    clear_err();
    run_access(1'b0, 4'h1, 32'h3000_0000, NEVER, 32'h0, -1);
    model_access(1'b1, 32'h3000_0000, NEVER, 32'h0, 1'b0, be, ee);
    n_vec++; if (ob_wb !== TO + 1) begin n_err++; $display("FAIL wto_busy: got %0d want %0d", ob_wb, TO + 1); end
    n_vec++; if (err !== 1'b1 || err_addr !== 32'h3000_0000) begin n_err++; $display("FAIL wto_err: got %b/%h want 1/30000000", err, err_addr); end
  endtask

  task automatic test_timeout_boundary();
    int be; bit ee;
    clear_err();
    run_access(1'b1, 4'h0, 32'h2000_0004, TO, 32'hCAFE_F00D, -1);
    model_access(1'b0, 32'h2000_0004, TO, 32'hCAFE_F00D, 1'b0, be, ee);
    n_vec++; if (ob_rb !== TO) begin n_err++; $display("FAIL bnd_rd_busy: got %0d want %0d", ob_rb, TO); end
    n_vec++; if (ob_rdata !== 32'hCAFE_F00D) begin n_err++; $display("FAIL bnd_rd_data: got %h want cafef00d", ob_rdata); end
    run_access(1'b0, 4'h8, 32'h1000_0008, TO, 32'h0, -1);
    model_access(1'b1, 32'h1000_0008, TO, 32'h0, 1'b0, be, ee);
    n_vec++; if (ob_wb !== TO) begin n_err++; $display("FAIL bnd_wr_busy: got %0d want %0d", ob_wb, TO); end
    run_access(1'b0, 4'h2, 32'h0000_0008, 0, 32'h0, -1);
    model_access(1'b1, 32'h0000_0008, 0, 32'h0, 1'b0, be, ee);
    n_vec++; if (ob_wb !== 0 || ob_strobes !== 1) begin n_err++; $display("FAIL wr_same_cycle: got busy %0d pulses %0d want 0/1", ob_wb, ob_strobes); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL bnd_err: got %b want 0", err); end
  endtask

  task automatic test_reset_mid();
    int be; bit ee; int activity;
    @(negedge clk);
    m_addr = 32'h1000_0040; m_rstrb = 1'b1; m_wmask = 4'h0; s_rvalid = '0; s_wready = '0;
    @(negedge clk); m_rstrb = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    n_vec++; if (m_rbusy !== 1'b0) begin n_err++; $display("FAIL rm_rbusy: got %b want 0", m_rbusy); end
    n_vec++; if (m_rdata !== 32'h0) begin n_err++; $display("FAIL rm_rdata: got %h want 0", m_rdata); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rm_err: got %b want 0", err); end
    @(negedge clk); rst = 1'b0;
    exp_rdata = '0; exp_err = 1'b0; exp_err_addr = '0;
    activity = 0;
    repeat (3) begin
      @(negedge clk); #1;
      activity += $countones(s_ren) + $countones(s_wen) + int'(m_rbusy) + int'(m_wbusy);
    end
    n_vec++; if (activity !== 0) begin n_err++; $display("FAIL rm_reissue: got %0d active cycles want 0", activity); end
    run_access(1'b1, 4'h0, 32'h1000_0040, 2, 32'h0BAD_CAFE, -1);
    model_access(1'b0, 32'h1000_0040, 2, 32'h0BAD_CAFE, 1'b0, be, ee);
    n_vec++; if (ob_rb !== be || ob_rdata !== exp_rdata) begin n_err++; $display("FAIL rm_next_read: got busy %0d data %h want %0d/%h", ob_rb, ob_rdata, be, exp_rdata); end
  endtask

  task automatic test_collision();
    int be; bit ee;
    run_access(1'b1, 4'hF, 32'h3000_0008, 2, 32'h0, -1);
    model_access(1'b1, 32'h3000_0008, 2, 32'h0, 1'b0, be, ee);
    n_vec++; if (ob_wen !== 4'b1000 || ob_ren !== 4'b0000) begin n_err++; $display("FAIL col_strobe: got wen %b ren %b want 1000/0000", ob_wen, ob_ren); end
    n_vec++; if (ob_strobes !== 1) begin n_err++; $display("FAIL col_pulses: got %0d want 1", ob_strobes); end
    n_vec++; if (ob_wb !== be || ob_rb !== 0) begin n_err++; $display("FAIL col_busy: got w%0d r%0d want w%0d r0", ob_wb, ob_rb, be); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL col_err: got %b want 0", err); end
  endtask

  task automatic test_random();
    int be, idx, lat; bit ee, wr, rd, clr, mapped;
    logic [31:0] addr, sdata; logic [3:0] wm, oh;
    for (int n = 0; n < 60; n++) begin
      idx   = $urandom_range(0, 7);
      addr  = {4'(idx), 28'($urandom)};
      wr    = 1'($urandom_range(0, 1));
      rd    = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      wm    = wr ? 4'($urandom_range(1, 15)) : 4'h0;
      sdata = $urandom;
      clr   = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 4))
        0:       lat = wr ? 0 : 1;
        1, 2:    lat = $urandom_range(1, TO);
        3:       lat = TO;
        default: lat = ($urandom_range(0, 1) == 1) ? TO + 1 : NEVER;
      endcase
      mapped = idx < NS;
      oh     = mapped ? 4'(1 << idx) : 4'h0;
      run_access(rd, wm, addr, lat, sdata, clr ? 0 : -1);
      model_access(wr, addr, lat, sdata, clr, be, ee);
      n_vec++; if (ob_hang) begin n_err++; $display("FAIL rnd%0d_hang: access never completed", n); end
      n_vec++; if (ob_ren !== (wr ? 4'h0 : oh) || ob_wen !== (wr ? oh : 4'h0) || ob_strobes !== int'(mapped)) begin
        n_err++; $display("FAIL rnd%0d_strobe: got ren %b wen %b pulses %0d want onehot %b wr %b", n, ob_ren, ob_wen, ob_strobes, oh, wr); end
      n_vec++; if (ob_rb !== (wr ? 0 : be) || ob_wb !== (wr ? be : 0)) begin
        n_err++; $display("FAIL rnd%0d_busy: got r%0d w%0d want %0d (wr %b lat %0d)", n, ob_rb, ob_wb, be, wr, lat); end
      n_vec++; if (ob_rdata !== exp_rdata) begin n_err++; $display("FAIL rnd%0d_rdata: got %h want %h", n, ob_rdata, exp_rdata); end
      n_vec++; if (err !== exp_err || err_addr !== exp_err_addr) begin
        n_err++; $display("FAIL rnd%0d_err: got %b/%h want %b/%h", n, err, err_addr, exp_err, exp_err_addr); end
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write();
    test_unmapped();
    test_timeout();
    test_timeout_boundary();
    test_reset_mid();
    test_collision();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/bus_fabric.md
Name: bus_fabric

Overview:
- Parametrised single-master, N-slave interconnect between the FemtoRV32 memory port and the SoC slaves (RAM, gpio_ip, uart_ip, future IPs).
- Replaces the fixed three-way select and the combinational read mux.
- Decodes the region field of the address into one-hot strobes and supports multi-cycle slaves through rvalid/wready handshakes, driving mem_rbusy/mem_wbusy back to the core.
- Adds a per-access timeout and unmapped-address error reporting.

Parameters:
N_SLAVES, 4, number of slave ports; slave i owns region value i (1..16)
DATA_W, 32, data width
SEL_MSB, 31, top bit of region field
SEL_LSB, 28, bottom bit of region field; offset = m_addr[SEL_LSB-1:0]
TIMEOUT, 15, wait cycles before a pending access is aborted (1..255)
ERR_DATA, 32'hDEAD_BEEF, read data returned on error/timeout

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
m_addr  in  32  core address, stable while busy
m_wdata  in  DATA_W  core write data
m_wmask  in  DATA_W/8  core byte write mask; nonzero = write request
m_rstrb  in  1  core read strobe
m_rdata  out  DATA_W  registered read data
m_rbusy  out  1  read in progress
m_wbusy  out  1  write in progress
s_addr  out  32  {zeros, m_addr[SEL_LSB-1:0]}, combinational
s_wdata  out  DATA_W  m_wdata passthrough
s_wstrb  out  DATA_W/8  m_wmask passthrough
s_ren  out  N_SLAVES  one-hot read pulse
s_wen  out  N_SLAVES  one-hot write pulse
s_rdata  in  N_SLAVES*DATA_W  slave i data at [i*DATA_W +: DATA_W]
s_rvalid  in  N_SLAVES  slave read data valid
s_wready  in  N_SLAVES  slave write accepted
err  out  1  sticky error flag
err_addr  out  32  address of first unacknowledged error
err_clr  in  1  clears err

Behaviour:
- Reset values: m_rdata=0, m_rbusy=0, m_wbusy=0, err=0, err_addr=0, state IDLE, timeout counter 0.
- Decode: idx = m_addr[SEL_MSB:SEL_LSB]. Mapped iff idx < N_SLAVES.
- FSM states: IDLE, RD_WAIT, WR_WAIT, ERR.
- IDLE, m_rstrb=1, mapped, m_wmask=0:
  - s_ren[idx]=1 in the same cycle (combinational).
  - Register tgt=idx; next state RD_WAIT.
- IDLE, m_wmask!=0, mapped:
  - s_wen[idx]=1 in the same cycle.
  - Register tgt; next state WR_WAIT.
  - If m_rstrb is also 1, the write wins and the read is dropped without error.
- IDLE, request to an unmapped region:
  - No slave strobe.
  - Next state ERR; err_addr latched only if err=0.
- RD_WAIT:
  - m_rbusy=1 (registered, so first high the cycle after the strobe).
  - On s_rvalid[tgt]: m_rdata <= slave tgt data; state IDLE.
  - Minimum read latency: strobe at T, 1-cycle slave valid at T+1, m_rbusy low and data valid at T+2.
  - s_rvalid from non-target slaves is ignored.
- WR_WAIT:
  - m_wbusy=1.
  - On s_wready[tgt]: state IDLE.
  - s_wready in the strobe cycle itself is also accepted; state goes straight to IDLE, busy never rises.
- ERR (1 cycle):
  - Read: m_rdata <= ERR_DATA.
  - err <= 1. Busy stays high during ERR; returns to IDLE.
- Timeout:
  - 8-bit counter clears on entering a WAIT state and increments each WAIT cycle without a response.
  - When the count reaches TIMEOUT, the access is aborted via ERR, with the same effects as unmapped.
  - A response arriving in the same cycle the limit is reached wins; no error.
- Requests not in IDLE: ignored. The core must hold them while busy, so there is no re-strobe.
- err: err_clr clears it. Simultaneous set and clear: set wins.
- Reset mid-access: immediate return to reset values; no pending strobe is reissued.
- s_ren and s_wen are never high for more than one cycle per access and are never high for two slaves at once.

Test Plan:
1. Read from slave 0 with 1-cycle rvalid returning 0x1234_5678 -> s_ren=0001 for 1 cycle; m_rbusy high exactly 1 cycle (T+1); m_rdata=0x1234_5678 at T+2; err=0.
2. Write to slave 2 with wmask=4'b0011, wready after 3 cycles -> s_wen=0100 one pulse; s_wstrb=0011; m_wbusy high 3 cycles then low; s_addr upper bits zero.
3. Read address 0x5000_0010 with N_SLAVES=4 -> no s_ren; m_rdata=0xDEAD_BEEF; err=1; err_addr=0x5000_0010.
4. Read slave 1 that never asserts rvalid, TIMEOUT=15 -> abort after 15 wait cycles, m_rdata=ERR_DATA, err=1; a second error leaves err_addr unchanged; err_clr -> err=0.
5. Pulse rst in RD_WAIT cycle 2 -> m_rbusy=0, m_rdata=0, state IDLE; next read completes normally.
6. m_rstrb and m_wmask=4'hF together to slave 3 -> only s_wen[3] pulses, s_ren stays 0, err=0.
